// File: rtl/event_profiler_array.sv
// event_profiler_array: bank of NUM_CH independent event counters.
// Each channel counts either rising edges or high cycles of its strobe.
// On overflow a channel either wraps or saturates, and sets a sticky flag.
// A shadow bank captures all live counts in a single cycle so that
// software can read every channel coherently.
module event_profiler_array #(
    parameter int NUM_CH   = 8,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [NUM_CH-1:0]         mode,
    input  logic [NUM_CH-1:0]         event_in,
    input  logic                      snapshot,
    output logic [NUM_CH*CNT_W-1:0]   counters,
    output logic [NUM_CH*CNT_W-1:0]   snap_counters,
    output logic [NUM_CH-1:0]         overflow,
    output logic                      snap_valid
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               SAT_EN  = (SATURATE != 0);

    // Live and shadow counters are kept as packed 2-D arrays, so the flat
    // output buses are plain wires of the same width.
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] snap_q;
    logic [NUM_CH-1:0]            prev_q;
    logic [NUM_CH-1:0]            ovf_q;
    logic [NUM_CH-1:0]            ovf_d;
    logic [NUM_CH-1:0]            inc;
    logic                         snap_valid_q;

    // Per-channel increment strobe. Level mode counts every high cycle;
    // edge mode counts only a high sample whose previous sample was low.
    assign inc = {NUM_CH{enable & ~clear}} & event_in & (mode | ~prev_q);

    // Next counter value and overflow flag for each channel.
    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path
        // can leave a signal unassigned and infer a latch.
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (inc[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = SAT_EN ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // State update: rst beats clear, and clear beats counting. A snapshot
    // captures the pre-edge counts, so it still sees them when clear is set.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let the snapshot read cnt_q as it
        // was before this edge, even though cnt_q is written here too.
        if (rst) begin
            cnt_q        <= '0;
            snap_q       <= '0;
            prev_q       <= '0;
            ovf_q        <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            if (snapshot) begin
                snap_q       <= cnt_q;
                snap_valid_q <= 1'b1;
            end
            if (clear) begin
                cnt_q  <= '0;
                prev_q <= '0;
                ovf_q  <= '0;
            end else begin
                cnt_q  <= cnt_d;
                prev_q <= event_in;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign counters      = cnt_q;
    assign snap_counters = snap_q;
    assign overflow      = ovf_q;
    assign snap_valid    = snap_valid_q;

endmodule

// File: tb/tb_event_profiler_array.sv
// Self-checking bench for event_profiler_array (8 channels, 8-bit counters).
// A driver applies directed and random stimulus, steps a behavioural model
// and queues the expected outputs; a monitor pops and compares every cycle.
module tb_event_profiler_array;

    localparam int NUM_CH   = 8;
    localparam int CNT_W    = 8;
    localparam int SATURATE = 0;
    localparam int W        = NUM_CH * CNT_W;
    localparam longint unsigned MAX = (longint'(1) << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable = 1'b0;
    logic                clear = 1'b0;
    logic                snapshot = 1'b0;
    logic [NUM_CH-1:0]   mode = '0;
    logic [NUM_CH-1:0]   event_in = '0;
    logic [W-1:0]        counters;
    logic [W-1:0]        snap_counters;
    logic [NUM_CH-1:0]   overflow;
    logic                snap_valid;

    always #5 clk = ~clk;

    event_profiler_array #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .SATURATE(SATURATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .mode         (mode),
        .event_in     (event_in),
        .snapshot     (snapshot),
        .counters     (counters),
        .snap_counters(snap_counters),
        .overflow     (overflow),
        .snap_valid   (snap_valid)
    );

    typedef struct {
        logic [W-1:0]      cnt;
        logic [W-1:0]      snap;
        logic [NUM_CH-1:0] ovf;
        logic              sv;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural model: plain integer counts per channel.
    longint unsigned m_cnt[NUM_CH];
    longint unsigned m_snap[NUM_CH];
    bit              m_ovf[NUM_CH];
    bit              m_prev[NUM_CH];
    bit              m_sv;

    int vectors     = 0;
    int miscompares = 0;
    bit done        = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] chan(input logic [W-1:0] v, input int i);
        return W'(v[i*CNT_W +: CNT_W]);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        exp_t e;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
            end
            m_sv = 0;
        end else begin
            if (snapshot) begin
                for (int i = 0; i < NUM_CH; i++) m_snap[i] = m_cnt[i];
                m_sv = 1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (clear) begin
                    m_cnt[i] = 0; m_ovf[i] = 0; m_prev[i] = 0;
                end else begin
                    if (enable && event_in[i] && (mode[i] || !m_prev[i])) begin
                        if (m_cnt[i] == MAX) begin
                            m_ovf[i] = 1;
                            m_cnt[i] = (SATURATE != 0) ? MAX : 0;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                    m_prev[i] = event_in[i];
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            e.cnt[i*CNT_W +: CNT_W]  = CNT_W'(m_cnt[i]);
            e.snap[i*CNT_W +: CNT_W] = CNT_W'(m_snap[i]);
            e.ovf[i]                 = m_ovf[i];
        end
        e.sv = m_sv;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of inputs (called at a falling edge), queue the
    // expectation, and return at the next falling edge.
    task automatic drive(input bit r, input bit en, input bit cl, input bit sn,
                         input logic [NUM_CH-1:0] md, input logic [NUM_CH-1:0] ev);
        rst = r; enable = en; clear = cl; snapshot = sn; mode = md; event_in = ev;
        model_step();
        @(negedge clk);
    endtask

    // Monitor: one expectation is consumed per clock edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("counters", counters, e.cnt);
                check("snap_counters", snap_counters, e.snap);
                check("overflow", W'(overflow), W'(e.ovf));
                check("snap_valid", W'(snap_valid), W'(e.sv));
            end else if (done) begin
                break;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Driver: directed scenarios first, then random traffic.
    initial begin : driver
        logic [NUM_CH-1:0] md;
        logic [W-1:0]      exp_ch2;
        bit r, en, cl, sn;
        exp_ch2 = (SATURATE != 0) ? W'(MAX) : W'(1);
        @(negedge clk);
        drive(1, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        check("reset_counters", counters, '0);
        check("reset_snap_valid", W'(snap_valid), '0);

        // Three separated pulses on ch0 in edge mode.
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0, '0, 8'h01);
            drive(0, 1, 0, 0, '0, 8'h00);
        end
        check("t1_all_channels", counters, W'(3));

        // Level mode on ch1 for 10 cycles, then edge mode for the same stimulus.
        for (int k = 0; k < 10; k++) drive(0, 1, 0, 0, 8'h02, 8'h02);
        drive(0, 1, 0, 0, 8'h02, 8'h00);
        check("t2_level_ch1", chan(counters, 1), W'(10));
        drive(0, 1, 1, 0, 8'h02, 8'h00);
        for (int k = 0; k < 10; k++) drive(0, 1, 0, 0, 8'h00, 8'h02);
        drive(0, 1, 0, 0, 8'h00, 8'h00);
        check("t2_edge_ch1", chan(counters, 1), W'(1));

        // 257 edges on ch2 overflow an 8-bit counter.
        drive(0, 1, 1, 0, 8'h00, 8'h00);
        for (int k = 0; k < 257; k++) begin
            drive(0, 1, 0, 0, 8'h00, 8'h04);
            drive(0, 1, 0, 0, 8'h00, 8'h00);
        end
        check("t3_ch2", chan(counters, 2), exp_ch2);
        check("t3_overflow", W'(overflow), W'(8'h04));
        drive(0, 1, 0, 1, 8'h00, 8'h00);
        check("t3_snap_ch2", chan(snap_counters, 2), exp_ch2);

        // enable low freezes ch3; clear zeroes live state but not the shadow.
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 0, 8'h08, 8'h08);
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 8'h08, 8'h08);
        check("t4_hold_ch3", chan(counters, 3), W'(4));
        drive(0, 1, 1, 0, 8'h08, 8'h08);
        check("t4_clear_counters", counters, '0);
        check("t4_clear_overflow", W'(overflow), '0);
        check("t4_snap_kept", chan(snap_counters, 2), exp_ch2);

        // Snapshot coincident with an event, then snapshot with clear.
        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 0, 0, 8'h00, 8'h01);
            drive(0, 1, 0, 0, 8'h00, 8'h00);
        end
        drive(0, 1, 0, 1, 8'h00, 8'h01);
        check("t5_snap_ch0", chan(snap_counters, 0), W'(7));
        check("t5_live_ch0", chan(counters, 0), W'(8));
        check("t5_snap_valid", W'(snap_valid), W'(1));
        drive(0, 1, 1, 1, 8'h00, 8'h00);
        check("t5_snapclr_snap", chan(snap_counters, 0), W'(8));
        check("t5_snapclr_live", counters, '0);

        // rst mid-count with a held level, then counting resumes.
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 8'h10, 8'h10);
        drive(1, 1, 0, 0, 8'h10, 8'h10);
        check("t6_rst_counters", counters, '0);
        check("t6_rst_snap", snap_counters, '0);
        check("t6_rst_valid", W'(snap_valid), '0);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 8'h10, 8'h10);
        check("t6_resume_ch4", chan(counters, 4), W'(3));

        // Random traffic.
        md = $urandom;
        for (int k = 0; k < 1500; k++) begin
            r  = ($urandom_range(0, 99) == 0);
            en = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 59) == 0);
            sn = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) md = $urandom;
            drive(r, en, cl, sn, md, NUM_CH'($urandom));
        end
        drive(0, 0, 0, 0, md, '0);
        done = 1'b1;
    end

endmodule
